// File: rtl/branch_predictor_unit.sv
// Branch predictor: BHT of 2-bit counters + tagged BTB, with table-clear sequencer.
// Define BPU_GSHARE_EN for gshare indexing with speculative GHR; default is bimodal.
module branch_predictor_unit #(
    parameter int         BHT_IDX_W = 8,
    parameter int         BTB_IDX_W = 6,
    parameter int         GHR_W     = 8,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_tables,
    output logic              ready,
    input  logic              lookup_en,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              update_en,
    input  logic [31:0]       update_pc,
    input  logic [GHR_W-1:0]  update_ghr,
    input  logic              update_is_cond,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              update_mispredict
);

    localparam int TAG_W = 30 - BTB_IDX_W;
    localparam int PTR_W = (BHT_IDX_W > BTB_IDX_W) ? BHT_IDX_W : BTB_IDX_W;
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam logic [PTR_W-1:0] PTR_LAST = '1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] up_ghr;

    logic [1:0]       bht_mem  [BHT_N];
    logic             btb_vld  [BTB_N];
    logic [TAG_W-1:0] btb_tag  [BTB_N];
    logic [31:0]      btb_tgt  [BTB_N];
    logic             btb_cond [BTB_N];

    logic [BHT_IDX_W-1:0] lk_bht_idx, up_bht_idx;
    logic [BTB_IDX_W-1:0] lk_btb_idx, up_btb_idx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic [1:0]           lk_ctr, up_ctr, ctr_nxt;
    logic                 lk_cond;

    logic                 bht_we, btb_we;
    logic [BHT_IDX_W-1:0] bht_wa;
    logic [BTB_IDX_W-1:0] btb_wa;
    logic [1:0]           bht_wd;
    logic                 btb_wv, btb_wcond;
    logic [TAG_W-1:0]     btb_wtag;
    logic [31:0]          btb_wtgt;
    logic                 bht_clr_ok, btb_clr_ok;

    assign ready = (state_q == S_RUN);

    assign lk_btb_idx = lookup_pc[BTB_IDX_W+1:2];
    assign lk_tag     = lookup_pc[31:BTB_IDX_W+2];
    assign lk_bht_idx = lookup_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
    assign lk_ctr     = bht_mem[lk_bht_idx];
    assign lk_cond    = btb_cond[lk_btb_idx];

    assign pred_hit    = ready & btb_vld[lk_btb_idx]
                       & (btb_tag[lk_btb_idx] == lk_tag);
    assign pred_taken  = pred_hit & (~lk_cond | lk_ctr[1]);
    assign pred_target = pred_hit ? btb_tgt[lk_btb_idx] : 32'h0;
    assign pred_ghr    = ready ? ghr : '0;

    assign up_btb_idx = update_pc[BTB_IDX_W+1:2];
    assign up_tag     = update_pc[31:BTB_IDX_W+2];
    assign up_bht_idx = update_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(up_ghr);
    assign up_ctr     = bht_mem[up_bht_idx];

    always_comb begin
        ctr_nxt = up_ctr;
        if (update_taken) begin
            if (up_ctr != 2'd3) ctr_nxt = up_ctr + 2'd1;
        end else begin
            if (up_ctr != 2'd0) ctr_nxt = up_ctr - 2'd1;
        end
    end

    // The clear pointer spans the larger table; the smaller one skips out-of-range slots.
    assign bht_clr_ok = ((ptr_q >> BHT_IDX_W) == '0);
    assign btb_clr_ok = ((ptr_q >> BTB_IDX_W) == '0);

    always_comb begin
        bht_we    = 1'b0;
        bht_wa    = up_bht_idx;
        bht_wd    = ctr_nxt;
        btb_we    = 1'b0;
        btb_wa    = up_btb_idx;
        btb_wv    = 1'b1;
        btb_wtag  = up_tag;
        btb_wtgt  = update_target;
        btb_wcond = update_is_cond;
        if (!ready) begin
            bht_we    = bht_clr_ok;
            bht_wa    = ptr_q[BHT_IDX_W-1:0];
            bht_wd    = CNT_INIT;
            btb_we    = btb_clr_ok;
            btb_wa    = ptr_q[BTB_IDX_W-1:0];
            btb_wv    = 1'b0;
            btb_wtag  = '0;
            btb_wtgt  = '0;
            btb_wcond = 1'b0;
        end else if (update_en) begin
            bht_we = update_is_cond;
            btb_we = update_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (bht_we) bht_mem[bht_wa] <= bht_wd;
        if (btb_we) begin
            btb_vld[btb_wa]  <= btb_wv;
            btb_tag[btb_wa]  <= btb_wtag;
            btb_tgt[btb_wa]  <= btb_wtgt;
            btb_cond[btb_wa] <= btb_wcond;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) state_d = S_RUN;
                if (flush_tables) begin
                    ptr_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_RUN: begin
                if (flush_tables) begin
                    ptr_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // Repair from the resolved snapshot beats the wrong-path lookup shift.
    always_comb begin
        ghr_d = ghr_q;
        if (!ready || flush_tables) begin
            ghr_d = '0;
        end else if (update_en && update_mispredict) begin
            ghr_d = update_is_cond ? GHR_W'({update_ghr, update_taken})
                                   : update_ghr;
        end else if (lookup_en && pred_hit && lk_cond) begin
            ghr_d = GHR_W'({ghr_q, lk_ctr[1]});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

    assign ghr    = ghr_q;
    assign up_ghr = update_ghr;
`else
    logic unused_cfg;

    assign ghr        = '0;
    assign up_ghr     = '0;
    assign unused_cfg = ^{lookup_en, update_ghr, update_mispredict};
`endif

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0]};

endmodule
